id_ex_pipe_reg: RTL and testbench
=================================

Name: id_ex_pipe_reg

Overview:
- Decode-to-execute pipeline register.
- Captures the decode-stage bundle each cycle: PC, instruction, register-file read data, the 32-bit extended immediate from the immediate extender, write-back register number and Tnew.
- Presents the bundle to the execute stage (ALU B-mux, MDU, forwarding compare).
- Handles bubble insertion on hazard stall, flush, downstream hold, and a saturating bubble performance counter.

Parameters:
- WIDTH, 32, datapath width of pc/instr/rs/rt/ext fields
- TNEW_W, 2, width of Tnew field
- CNT_W, 16, width of bubble performance counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hazard unit: D held, insert bubble into E
- flush  in  1  squash: insert bubble into E
- hold  in  1  downstream freeze: E retains contents
- pc_d  in  WIDTH  decode PC
- instr_d  in  WIDTH  decode instruction word
- rs_data_d  in  WIDTH  forwarded rs value
- rt_data_d  in  WIDTH  forwarded rt value
- ext_d  in  WIDTH  extended immediate (sign/zero/high-shifted) from extender
- a3_d  in  5  destination register number, 0 if none
- tnew_d  in  TNEW_W  cycles until result available, counted from E
- pc_e, instr_e, rs_data_e, rt_data_e, ext_e  out  WIDTH  registered copies
- a3_e  out  5  registered destination
- tnew_e  out  TNEW_W  registered Tnew
- valid_e  out  1  1 = real instruction, 0 = bubble
- bubble_cnt  out  CNT_W  bubbles inserted since reset

Behaviour:
- Reset: asserting reset clears all outputs to 0 immediately (asynchronous) and holds them at 0 while asserted. Covers valid_e and bubble_cnt. instr_e = 0 is sll $0,$0,0, i.e. NOP.
- Reset mid-operation: discards current contents. The first rising edge after deassertion applies normal priority.
- Per-edge priority: reset > flush > hold > stall > load.
- flush=1 (bubble):
  - instr_e, a3_e, tnew_e, rs_data_e, rt_data_e, ext_e <= 0; valid_e <= 0.
  - pc_e <= pc_d.
  - bubble_cnt increments.
  - flush overrides hold.
- hold=1 (flush=0): every output keeps its value; stall ignored; bubble_cnt unchanged.
- stall=1 (flush=0, hold=0): same bubble as flush; bubble_cnt increments.
- load (all three low):
  - every *_e <= corresponding *_d; valid_e <= 1.
  - ext_e is bit-exact ext_d, no re-extension.
- a3_d = 0 on load: tnew_e is forced to 0, so $0 never forms a forwarding target.
- Latency: one cycle, D at edge n → E visible after edge n.
- bubble_cnt: saturates at all-ones and does not wrap; increments at most once per edge.
- No combinational path from any input to any output.

Optional Feature:
- Macro: ID_EX_BD_EN.
- When defined, adds two ports:
  - bd_d  in  1  instruction is in a branch delay slot
  - bd_e  out  1  registered flag
- bd_e rules:
  - load: bd_e <= bd_d
  - hold: bd_e keeps its value
  - stall bubble: bd_e <= bd_d, preserving pc/bd for precise exception reporting
  - flush bubble: bd_e <= 0
  - reset: bd_e = 0
- When undefined: ports are absent and behaviour is otherwise identical.

Test Plan:
- Reset: drive reset=1 mid-run with all _d = 32'hFFFFFFFF → all outputs 0 immediately, before any clock edge. After release and one load edge, valid_e=1 and instr_e=32'hFFFFFFFF.
- Load of an extended immediate:
  - ext_d=32'hFFFF8000, pc_d=32'h00003004, a3_d=5'd8, tnew_d=2'd1, all controls low.
  - After one edge: ext_e=32'hFFFF8000, pc_e=32'h00003004, a3_e=8, tnew_e=1, valid_e=1.
- Stall bubble: stall=1 for 3 edges with pc_d=32'h00003008 → instr_e=0, valid_e=0, a3_e=0, tnew_e=0, pc_e=32'h00003008, bubble_cnt increments by 3.
- Priority:
  - hold=1 and stall=1 for 2 edges → contents and bubble_cnt unchanged.
  - Then flush=1 with hold=1 → bubble inserted, bubble_cnt+1.
- $0 destination: load a3_d=0, tnew_d=2'd2 → tnew_e=0, valid_e=1.
- Counter saturation and optional feature:
  - Build with CNT_W=4, hold stall=1 for 20 edges → bubble_cnt stops at 4'hF.
  - With ID_EX_BD_EN defined, bd_d=1: stall bubble → bd_e=1; flush bubble → bd_e=0.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// Decode-to-execute pipeline register with bubble insertion, downstream hold and a saturating bubble counter.
// Optional branch-delay-slot flag tracking is enabled by defining ID_EX_BD_EN.
module id_ex_pipe_reg #(
  parameter int WIDTH  = 32,
  parameter int TNEW_W = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              hold,
  input  logic [WIDTH-1:0]  pc_d,
  input  logic [WIDTH-1:0]  instr_d,
  input  logic [WIDTH-1:0]  rs_data_d,
  input  logic [WIDTH-1:0]  rt_data_d,
  input  logic [WIDTH-1:0]  ext_d,
  input  logic [4:0]        a3_d,
  input  logic [TNEW_W-1:0] tnew_d,
  output logic [WIDTH-1:0]  pc_e,
  output logic [WIDTH-1:0]  instr_e,
  output logic [WIDTH-1:0]  rs_data_e,
  output logic [WIDTH-1:0]  rt_data_e,
  output logic [WIDTH-1:0]  ext_e,
  output logic [4:0]        a3_e,
  output logic [TNEW_W-1:0] tnew_e,
  output logic              valid_e,
  output logic [CNT_W-1:0]  bubble_cnt
`ifdef ID_EX_BD_EN
  ,
  input  logic              bd_d,
  output logic              bd_e
`endif
);

  logic insertBubble;
  logic cntFull;

  // flush wins over hold; a stall only bubbles when the stage is not frozen
  always_comb begin
    insertBubble = flush | (~hold & stall);
    cntFull      = &bubble_cnt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_e      <= '0;
      instr_e   <= '0;
      rs_data_e <= '0;
      rt_data_e <= '0;
      ext_e     <= '0;
      a3_e      <= '0;
      tnew_e    <= '0;
      valid_e   <= 1'b0;
    end else if (insertBubble) begin
      // the bubble keeps the decode PC so exception reporting stays precise
      pc_e      <= pc_d;
      instr_e   <= '0;
      rs_data_e <= '0;
      rt_data_e <= '0;
      ext_e     <= '0;
      a3_e      <= '0;
      tnew_e    <= '0;
      valid_e   <= 1'b0;
    end else if (!hold) begin
      pc_e      <= pc_d;
      instr_e   <= instr_d;
      rs_data_e <= rs_data_d;
      rt_data_e <= rt_data_d;
      ext_e     <= ext_d;
      a3_e      <= a3_d;
      // a write to $0 must never look like a pending forwarding source
      tnew_e    <= (a3_d == 5'd0) ? '0 : tnew_d;
      valid_e   <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_cnt <= '0;
    end else if (insertBubble && !cntFull) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

`ifdef ID_EX_BD_EN
  // a stall bubble inherits the delay-slot flag, a flush bubble clears it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bd_e <= 1'b0;
    end else if (flush) begin
      bd_e <= 1'b0;
    end else if (!hold) begin
      bd_e <= bd_d;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Randomized self-checking bench for id_ex_pipe_reg against a behavioural stage model.
// Built with CNT_W=4 so counter saturation is reachable; bd checks appear when ID_EX_BD_EN is defined.
module tb_id_ex_pipe_reg;
  localparam int WIDTH  = 32;
  localparam int TNEW_W = 2;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset, stall, flush, hold;
  logic [WIDTH-1:0] pc_d, instr_d, rs_data_d, rt_data_d, ext_d;
  logic [4:0] a3_d;
  logic [TNEW_W-1:0] tnew_d;
  logic [WIDTH-1:0] pc_e, instr_e, rs_data_e, rt_data_e, ext_e;
  logic [4:0] a3_e;
  logic [TNEW_W-1:0] tnew_e;
  logic valid_e;
  logic [CNT_W-1:0] bubble_cnt;
  logic bd_d;
  logic mBd;
`ifdef ID_EX_BD_EN
  logic bd_e;
`endif

  id_ex_pipe_reg #(.WIDTH(WIDTH), .TNEW_W(TNEW_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .hold(hold),
    .pc_d(pc_d), .instr_d(instr_d), .rs_data_d(rs_data_d), .rt_data_d(rt_data_d),
    .ext_d(ext_d), .a3_d(a3_d), .tnew_d(tnew_d),
    .pc_e(pc_e), .instr_e(instr_e), .rs_data_e(rs_data_e), .rt_data_e(rt_data_e),
    .ext_e(ext_e), .a3_e(a3_e), .tnew_e(tnew_e), .valid_e(valid_e),
    .bubble_cnt(bubble_cnt)
`ifdef ID_EX_BD_EN
    , .bd_d(bd_d), .bd_e(bd_e)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: the E-stage content as a record plus an unbounded bubble tally
  logic [WIDTH-1:0] mPc, mInstr, mRs, mRt, mExt;
  logic [4:0] mA3;
  logic [TNEW_W-1:0] mTnew;
  logic mValid;
  int mBubbles;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    {mPc, mInstr, mRs, mRt, mExt} = '0;
    mA3 = '0; mTnew = '0; mValid = 1'b0; mBubbles = 0; mBd = 1'b0;
  endtask

  task automatic modelEdge();
    if (flush || (stall && !hold)) begin
      mPc = pc_d; {mInstr, mRs, mRt, mExt} = '0;
      mA3 = '0; mTnew = '0; mValid = 1'b0;
      mBubbles++;
      mBd = flush ? 1'b0 : bd_d;
    end else if (!hold) begin
      mPc = pc_d; mInstr = instr_d; mRs = rs_data_d; mRt = rt_data_d; mExt = ext_d;
      mA3 = a3_d; mTnew = (a3_d == 0) ? '0 : tnew_d; mValid = 1'b1;
      mBd = bd_d;
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".pc"}, 64'(pc_e), 64'(mPc));
    checkOutput({tag, ".instr"}, 64'(instr_e), 64'(mInstr));
    checkOutput({tag, ".rs"}, 64'(rs_data_e), 64'(mRs));
    checkOutput({tag, ".rt"}, 64'(rt_data_e), 64'(mRt));
    checkOutput({tag, ".ext"}, 64'(ext_e), 64'(mExt));
    checkOutput({tag, ".a3"}, 64'(a3_e), 64'(mA3));
    checkOutput({tag, ".tnew"}, 64'(tnew_e), 64'(mTnew));
    checkOutput({tag, ".valid"}, 64'(valid_e), 64'(mValid));
    checkOutput({tag, ".cnt"}, 64'(bubble_cnt), 64'((mBubbles > CNT_MAX) ? CNT_MAX : mBubbles));
`ifdef ID_EX_BD_EN
    checkOutput({tag, ".bd"}, 64'(bd_e), 64'(mBd));
`endif
  endtask

  task automatic setData(input logic [31:0] pc, instr, rs, rt, ext, input logic [4:0] a3, input logic [1:0] tn);
    pc_d = pc; instr_d = instr; rs_data_d = rs; rt_data_d = rt; ext_d = ext; a3_d = a3; tnew_d = tn;
  endtask

  task automatic applyStimulus(input string tag, input logic s, input logic f, input logic h);
    stall = s; flush = f; hold = h;
    @(posedge clk);
    #1;
    modelEdge();
    checkAll(tag);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; hold = 1'b0; bd_d = 1'b0;
    setData('0, '0, '0, '0, '0, '0, '0);
    modelReset();
    #2;
    checkAll("por");
    @(posedge clk); #1;
    reset = 1'b0;

    // loads with an extended immediate, then a $0 destination
    setData(32'h00003004, 32'h2408FFFF, 32'h11, 32'h22, 32'hFFFF8000, 5'd8, 2'd1);
    applyStimulus("load_ext", 0, 0, 0);
    checkOutput("load_ext.exact", 64'(ext_e), 64'h0FFFF8000);
    checkOutput("load_ext.tnew", 64'(tnew_e), 64'd1);
    setData(32'h00003008, 32'h24000005, 32'h1, 32'h2, 32'h5, 5'd0, 2'd2);
    applyStimulus("load_zero", 0, 0, 0);
    checkOutput("zero_dst.tnew", 64'(tnew_e), 64'd0);
    checkOutput("zero_dst.valid", 64'(valid_e), 64'd1);

    // three stall bubbles carrying the decode PC
    setData(32'h00003008, 32'h12345678, 32'h3, 32'h4, 32'h6, 5'd9, 2'd2);
    bd_d = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus("stall", 1, 0, 0);
    checkOutput("stall.cnt3", 64'(bubble_cnt), 64'd3);
    checkOutput("stall.pc", 64'(pc_e), 64'h3008);
`ifdef ID_EX_BD_EN
    checkOutput("stall.bd", 64'(bd_e), 64'd1);
`endif

    // hold beats stall, flush beats hold
    setData(32'h0000300C, 32'hDEADBEEF, 32'h7, 32'h8, 32'h9, 5'd3, 2'd1);
    applyStimulus("load_pre_hold", 0, 0, 0);
    for (int i = 0; i < 2; i++) applyStimulus("hold_stall", 1, 0, 1);
    checkOutput("hold.cnt", 64'(bubble_cnt), 64'd3);
    checkOutput("hold.instr", 64'(instr_e), 64'hDEADBEEF);
    applyStimulus("flush_hold", 0, 1, 1);
    checkOutput("flush.cnt", 64'(bubble_cnt), 64'd4);
`ifdef ID_EX_BD_EN
    checkOutput("flush.bd", 64'(bd_e), 64'd0);
`endif

    // asynchronous reset mid-run with all-ones inputs
    setData('1, '1, '1, '1, '1, '1, '1);
    #2;
    reset = 1'b1;
    #1;
    modelReset();
    checkAll("async_rst");
    @(posedge clk); #1;
    checkAll("rst_held");
    reset = 1'b0;
    applyStimulus("rst_load", 0, 0, 0);
    checkOutput("rst_load.instr", 64'(instr_e), 64'hFFFFFFFF);
    checkOutput("rst_load.valid", 64'(valid_e), 64'd1);

    // saturation of the narrow counter
    for (int i = 0; i < 20; i++) applyStimulus("sat", 1, 0, 0);
    checkOutput("sat.cnt", 64'(bubble_cnt), 64'hF);

    // randomized mix, with one reset pulse part-way through
    reset = 1'b1; #1; modelReset(); checkAll("rand_rst");
    @(posedge clk); #1; reset = 1'b0;
    for (int i = 0; i < 300; i++) begin
      setData($urandom, $urandom, $urandom, $urandom, $urandom,
              ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), 2'($urandom));
      bd_d = 1'($urandom);
      applyStimulus("rand", ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 5) == 0));
      if (i == 150) begin
        reset = 1'b1; #1; modelReset(); checkAll("rand_midrst");
        @(posedge clk); #1; reset = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
